branch_resolver: RTL
====================

// Module: branch_resolver
// PURPOSE
//   Consumer side of the ALU flag interface. Accepts one conditional branch at a time from decode.
//   Waits until the ALU flags register {O,S,Z,C} reflects every earlier flag-writing op.
//   Evaluates the 4-bit condition, then either signals fall-through or drives a held redirect
//   (valid/ready) and a flush pulse to fetch. Also keeps saturating branch/taken counters.
// PARAMETERS
//   FLAG_LAT  1   cycles from flags_wr high until flags[] shows that op's result (>=1)
//   CNT_W     16  width of br_count / taken_count
// PORTS
//   clk            in   1      single clock; all state changes on posedge
//   rst            in   1      asynchronous, active-high reset
//   in_valid       in   1      branch request valid
//   in_ready       out  1      high only in IDLE; accept = in_valid & in_ready at posedge
//   in_cond        in   4      condition code (table below)
//   in_pc          in   16     PC of branch instruction (word address)
//   in_off         in   16     signed word offset; target = in_pc + in_off mod 2^16
//   flags          in   4      ALU flags {O,S,Z,C}, registered inside ALU
//   flags_wr       in   1      an ALU op writing flags is executing this cycle
//   resolve_valid  out  1      1-cycle pulse: branch resolved
//   resolve_taken  out  1      outcome; valid with resolve_valid, held afterwards
//   flush          out  1      1-cycle pulse, coincident with resolve_valid when taken
//   redirect_valid out  1      redirect request; held until redirect_ready
//   redirect_ready in   1      fetch accepts redirect_pc
//   redirect_pc    out  16     taken target; stable while redirect_valid
//   br_count       out  CNT_W  resolved branches, saturating
//   taken_count    out  CNT_W  taken branches, saturating
// BEHAVIOUR
//   Reset: state=IDLE, pend=0. All outputs 0 except in_ready=1.
//   Reset is asynchronous. Mid-operation it abandons the branch, and a held redirect is dropped.
//   pend counter runs in every state:
//     flags_wr=1 -> pend <= FLAG_LAT-1; else if pend!=0 -> pend <= pend-1.
//     Flags are "settled" in a cycle where pend==0 and flags_wr==0.
//     flags_wr=1 during EVAL therefore stalls the evaluation.
//   FSM:
//     IDLE  in_ready=1. On accept: latch cond, pc, and target = in_pc+in_off
//           (16-bit wrap, e.g. 0xFFFE + 0x0003 = 0x0001). Next state EVAL.
//     EVAL  in_ready=0. Stay while flags not settled. When settled, evaluate flags at that edge.
//           Not taken -> next cycle resolve_valid=1, resolve_taken=0; next state IDLE.
//           Taken -> next cycle resolve_valid=1, resolve_taken=1, flush=1,
//           redirect_valid=1, redirect_pc=target; next state REDIR.
//     REDIR in_ready=0. Hold redirect_valid and redirect_pc.
//           On redirect_ready at posedge: redirect_valid <= 0; next state IDLE.
//           redirect_ready already high in the first REDIR cycle completes in that cycle.
//   Minimum latency: accept edge E0, evaluate edge E1, resolve_valid high in cycle after E1.
//   Back-to-back not-taken branches: one accept per 3 cycles.
//   Conditions (C = unsigned borrow on sub):
//     0 always   1 Z       2 !Z      3 S       4 !S      5 C       6 !C      7 O
//     8 !O       9 !Z&(S==O)         10 S==O   11 S!=O   12 Z|(S!=O)
//     13 C (ult) 14 !C&!Z (ugt)      15 never
//   Counters update at the evaluate edge: br_count += 1; taken_count += taken.
//   Counters saturate at all-ones and do not wrap.
//   redirect_ready is ignored outside REDIR. in_valid is ignored outside IDLE.
// TESTING
//   1 cond=0, pc=0x0010, off=0x0005, no flags_wr
//     -> resolve_valid at accept+2 cycles, taken=1, flush=1, redirect_pc=0x0015.
//   2 flags=4'b0010 (Z), cond=2
//     -> resolve_taken=0, no flush, no redirect_valid, in_ready back high next cycle.
//   3 FLAG_LAT=3, flags_wr pulsed in accept cycle
//     -> evaluation delayed 2 cycles; pulse flags_wr again in EVAL -> delay reloads.
//   4 taken branch, redirect_ready low 4 cycles
//     -> redirect_valid/pc held stable 4 cycles, in_ready=0, a second in_valid is not accepted.
//   5 pc=0xFFFE, off=0x0003, cond=0 -> redirect_pc=0x0001.
//     Signed conds with {O,S}=2'b10: cond11 -> taken, cond10 -> not taken.
//   6 rst pulsed asynchronously while in REDIR
//     -> redirect_valid drops immediately, counters=0, in_ready=1.
//     CNT_W=2: four taken branches -> counters stay at 3.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Decode/ALU/fetch-facing signal bundle for branch_resolver.
// Handshakes: a transfer happens on a posedge where valid && ready; valid is held and its payload stays stable until then.
interface branch_resolver_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_cond;
  logic [15:0]      in_pc;
  logic [15:0]      in_off;
  logic [3:0]       flags;
  logic             flags_wr;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             flush;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [15:0]      redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output in_valid, in_cond, in_pc, in_off, flags, flags_wr, redirect_ready,
    input  in_ready, resolve_valid, resolve_taken, flush, redirect_valid,
           redirect_pc, br_count, taken_count
  );

  modport slave (
    input  in_valid, in_cond, in_pc, in_off, flags, flags_wr, redirect_ready,
    output in_ready, resolve_valid, resolve_taken, flush, redirect_valid,
           redirect_pc, br_count, taken_count
  );
endinterface

// File: rtl/branch_resolver.sv
// Resolves one conditional branch at a time once ALU flags have settled, then
// reports the outcome, issues a held redirect on taken, and keeps saturating counters.
module branch_resolver #(
  parameter int FLAG_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolver_if.slave  bus,
  output logic [1:0]        state_o
);
  localparam int PW = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
  localparam logic [PW-1:0] PEND_RELOAD = PW'(FLAG_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    pend_q;
  logic [3:0]       cond_q;
  logic [15:0]      target_q;
  logic             in_ready_q;
  logic             resolve_valid_q;
  logic             resolve_taken_q;
  logic             flush_q;
  logic             redirect_valid_q;
  logic [15:0]      redirect_pc_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] taken_count_q;

  logic settled;
  logic taken;
  logic f_o, f_s, f_z, f_c;

  always_comb begin
    settled = (pend_q == '0) && !bus.flags_wr;
    {f_o, f_s, f_z, f_c} = bus.flags;
    taken = 1'b0;
    case (cond_q)
      4'd0:    taken = 1'b1;
      4'd1:    taken = f_z;
      4'd2:    taken = !f_z;
      4'd3:    taken = f_s;
      4'd4:    taken = !f_s;
      4'd5:    taken = f_c;
      4'd6:    taken = !f_c;
      4'd7:    taken = f_o;
      4'd8:    taken = !f_o;
      4'd9:    taken = !f_z && (f_s == f_o);
      4'd10:   taken = (f_s == f_o);
      4'd11:   taken = (f_s != f_o);
      4'd12:   taken = f_z || (f_s != f_o);
      4'd13:   taken = f_c;
      4'd14:   taken = !f_c && !f_z;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      pend_q           <= '0;
      cond_q           <= '0;
      target_q         <= '0;
      in_ready_q       <= 1'b1;
      resolve_valid_q  <= 1'b0;
      resolve_taken_q  <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_count_q       <= '0;
      taken_count_q    <= '0;
    end else begin
      resolve_valid_q <= 1'b0;
      flush_q         <= 1'b0;

      if (bus.flags_wr)
        pend_q <= PEND_RELOAD;
      else if (pend_q != '0)
        pend_q <= pend_q - PW'(1);

      case (state_q)
        IDLE: begin
          // After a not-taken resolve, in_ready stays low for the resolve cycle.
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (bus.in_valid) begin
            cond_q     <= bus.in_cond;
            target_q   <= bus.in_pc + bus.in_off;
            in_ready_q <= 1'b0;
            state_q    <= EVAL;
          end
        end
        EVAL: begin
          if (settled) begin
            resolve_valid_q <= 1'b1;
            resolve_taken_q <= taken;
            if (br_count_q != '1)
              br_count_q <= br_count_q + CNT_W'(1);
            if (taken && (taken_count_q != '1))
              taken_count_q <= taken_count_q + CNT_W'(1);
            if (taken) begin
              flush_q          <= 1'b1;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= target_q;
              state_q          <= REDIR;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        REDIR: begin
          if (bus.redirect_ready) begin
            redirect_valid_q <= 1'b0;
            in_ready_q       <= 1'b1;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.resolve_valid  = resolve_valid_q;
  assign bus.resolve_taken  = resolve_taken_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.br_count       = br_count_q;
  assign bus.taken_count    = taken_count_q;
  assign state_o            = state_q;
endmodule
